// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and constants for the control-unit dispatcher
package cu_pkg;

    localparam int N_CLASS = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_DECODE     = 3'd3,
        ST_DISPATCH   = 3'd4,
        ST_BUSY       = 3'd5,
        ST_TRAP       = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10,
        CAUSE_MULTI   = 2'b11
    } trap_cause_t;

    // Opdecoder class bits; bits 30/31 are reserved and decode as illegal.
    localparam logic [31:0] MASK_ALU = 32'h0000_FFFF;
    localparam logic [31:0] MASK_LSU = 32'h00FF_0000;
    localparam logic [31:0] MASK_BRJ = 32'h0300_0000;
    localparam logic [31:0] MASK_FPU = 32'h3C00_0000;

    localparam logic [N_CLASS-1:0][31:0] CLASS_MASK = {MASK_FPU, MASK_BRJ, MASK_LSU, MASK_ALU};

    typedef struct packed {
        logic [19:0] spare;
        logic [3:0]  alu_op;
        logic [2:0]  sel_rd;
        logic        mem_wr;
        logic        mem_rd;
        logic        load_regfile;
        logic        load_pc;
        logic        sel_pc;
    } ctrl_bundle_t;

endpackage

// File: rtl/control_dispatcher_if.sv
// rtl/control_dispatcher_if.sv - dispatcher handshake, sub-FSM and status signals
interface control_dispatcher_if #(
    parameter int N_FSM  = 4,
    parameter int CTRL_W = 32
);
    logic                    run;
    logic [31:0]             code;
    logic                    fetch_done;
    logic [N_FSM-1:0]        fsm_done;
    logic [N_FSM*CTRL_W-1:0] fsm_ctrl;

    logic                    fetch_start;
    logic                    load_ir;
    logic [N_FSM-1:0]        fsm_start;
    logic [CTRL_W-1:0]       ctrl_out;
    logic                    busy;
    logic                    trap;
    logic [1:0]              trap_cause;
    logic [31:0]             retired;

    modport master (
        input  run, code, fetch_done, fsm_done, fsm_ctrl,
        output fetch_start, load_ir, fsm_start, ctrl_out, busy, trap, trap_cause, retired
    );

    modport slave (
        output run, code, fetch_done, fsm_done, fsm_ctrl,
        input  fetch_start, load_ir, fsm_start, ctrl_out, busy, trap, trap_cause, retired
    );
endinterface

// File: rtl/dispatch_match.sv
// rtl/dispatch_match.sv - combinational opcode class to sub-FSM grant encoder
module dispatch_match
    import cu_pkg::*;
#(
    parameter int                      N_FSM      = 4,
    parameter int                      GW         = 2,
    parameter logic [N_FSM-1:0][31:0]  CLASS_MASK = cu_pkg::CLASS_MASK
) (
    input  logic [31:0]   code,
    output logic [GW-1:0] grant,
    output logic          none,
    output logic          multi
);
    logic [N_FSM-1:0] match;

    always_comb begin
        match = '0;
        grant = '0;
        for (int i = 0; i < N_FSM; i++) begin
            match[i] = |(code & CLASS_MASK[i]);
            if (match[i]) grant = GW'(i);
        end
    end

    assign none  = (match == '0);
    assign multi = ($countones(match) > 1);

endmodule

// File: rtl/control_dispatcher.sv
// rtl/control_dispatcher.sv - fetch/decode/dispatch sequencer with watchdog, trap and retire count
module control_dispatcher
    import cu_pkg::*;
#(
    parameter int                     N_FSM      = 4,
    parameter int                     CTRL_W     = 32,
    parameter int                     TIMEOUT    = 64,
    parameter logic [N_FSM-1:0][31:0] CLASS_MASK = cu_pkg::CLASS_MASK
) (
    input  logic               clk,
    input  logic               rst_n,
    control_dispatcher_if.master bus
);
    localparam int GW   = (N_FSM > 1) ? $clog2(N_FSM) : 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d, match_grant;
    logic              match_none, match_multi;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [31:0]       retired_q, retired_d;
    logic              trap_q, trap_d;
    trap_cause_t       cause_q, cause_d;
    logic [CTRL_W-1:0] granted_ctrl;
    logic              granted_done;

    dispatch_match #(
        .N_FSM      (N_FSM),
        .GW         (GW),
        .CLASS_MASK (CLASS_MASK)
    ) u_match (
        .code  (bus.code),
        .grant (match_grant),
        .none  (match_none),
        .multi (match_multi)
    );

    assign granted_ctrl = bus.fsm_ctrl[int'(grant_q)*CTRL_W +: CTRL_W];
    assign granted_done = bus.fsm_done[grant_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            wd_q      <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            wd_q      <= wd_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        wd_d            = wd_q;
        retired_d       = retired_q;
        trap_d          = trap_q;
        cause_d         = cause_q;
        bus.fetch_start = 1'b0;
        bus.load_ir     = 1'b0;
        bus.fsm_start   = '0;
        bus.ctrl_out    = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                bus.fetch_start = 1'b1;
                state_d         = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                if (bus.fetch_done) begin
                    bus.load_ir = 1'b1;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (match_none) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else if (match_multi) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_MULTI;
                end else begin
                    grant_d = match_grant;
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                bus.fsm_start[grant_q] = 1'b1;
                bus.ctrl_out           = granted_ctrl;
                wd_d                   = '0;
                state_d                = ST_BUSY;
            end
            ST_BUSY: begin
                bus.ctrl_out = granted_ctrl;
                // done is checked first so it beats a watchdog expiry in the same cycle
                if (granted_done) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = bus.run ? ST_FETCH : ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_control_dispatcher.sv
// tb/tb_control_dispatcher.sv - table-driven directed bench for control_dispatcher
module tb_control_dispatcher;

    localparam int TIMEOUT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_dispatcher_if #(.N_FSM(4), .CTRL_W(32)) bus();

    control_dispatcher #(
        .N_FSM   (4),
        .CTRL_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] code;
        int          lat;
        int          done_cyc;
        logic [3:0]  stray;
        logic        run_keep;
        int          exp_g;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t        vecs [12];
    vec_t        hv;
    logic [31:0] ctrl_pat [4];
    logic [31:0] exp_ret;
    int          n_checks = 0;
    int          n_bad    = 0;
    int          cur      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: actual %h required %h", cur, name, act, exp);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n          = 1'b0;
        bus.run        = 1'b0;
        bus.code       = '0;
        bus.fetch_done = 1'b0;
        bus.fsm_done   = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = '0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_trap", bus.trap, 0);
        chk("rst_cause", bus.trap_cause, 0);
        chk("rst_retired", bus.retired, 0);
        chk("rst_ctrl", bus.ctrl_out, 0);
    endtask

    task automatic run_instr(input vec_t v);
        logic [3:0] onehot;
        int         k;
        bus.code = v.code;
        bus.run  = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.fetch_start !== 1'b1 && k < 6);
        chk("fetch_start", bus.fetch_start, 1);
        for (int j = 1; j <= v.lat; j++) begin
            @(negedge clk);
            if (j == v.lat) begin
                bus.fetch_done = 1'b1;
                #1;
                chk("load_ir", bus.load_ir, 1);
            end else begin
                chk("load_ir_early", bus.load_ir, 0);
            end
        end
        @(negedge clk);
        bus.fetch_done = 1'b0;
        chk("decode_start", bus.fsm_start, 0);
        chk("decode_ctrl", bus.ctrl_out, 0);
        chk("decode_busy", bus.busy, 1);
        @(negedge clk);
        if (v.exp_g < 0) begin
            chk("trap", bus.trap, 1);
            chk("trap_cause", bus.trap_cause, v.exp_cause);
            chk("trap_start", bus.fsm_start, 0);
            chk("trap_busy", bus.busy, 0);
            chk("trap_ctrl", bus.ctrl_out, 0);
            repeat (3) begin
                bus.fetch_done = 1'b1;
                @(negedge clk);
                chk("trap_hold_fetch", bus.fetch_start, 0);
                chk("trap_hold_load", bus.load_ir, 0);
                chk("trap_hold", bus.trap, 1);
                chk("trap_retired", bus.retired, exp_ret);
                bus.fetch_done = 1'b0;
            end
            return;
        end
        onehot = 4'b0001 << v.exp_g;
        chk("dispatch_start", bus.fsm_start, onehot);
        chk("dispatch_ctrl", bus.ctrl_out, ctrl_pat[v.exp_g]);
        bus.run = v.run_keep;
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(negedge clk);
            chk($sformatf("busy_ctrl_c%0d", n), bus.ctrl_out, ctrl_pat[v.exp_g]);
            if (n == 1) chk("busy_start", bus.fsm_start, 0);
            bus.fsm_done = v.stray;
            if (n == v.done_cyc) begin
                bus.fsm_done = v.stray | onehot;
                break;
            end
        end
        @(negedge clk);
        bus.fsm_done = '0;
        if (v.done_cyc == 0) begin
            chk("wd_trap", bus.trap, 1);
            chk("wd_cause", bus.trap_cause, v.exp_cause);
            chk("wd_retired", bus.retired, exp_ret);
            chk("wd_busy", bus.busy, 0);
            chk("wd_ctrl", bus.ctrl_out, 0);
        end else begin
            exp_ret = exp_ret + 32'd1;
            chk("retired", bus.retired, exp_ret);
            chk("no_trap", bus.trap, 0);
            chk("post_busy", bus.busy, v.run_keep);
            chk("post_fetch", bus.fetch_start, v.run_keep);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL time_limit: actual expired required finished");
        $fatal(1);
    end

    initial begin
        bus.run        = 1'b0;
        bus.code       = '0;
        bus.fetch_done = 1'b0;
        bus.fsm_done   = '0;
        ctrl_pat[0] = 32'hA1A1_0001;
        ctrl_pat[1] = 32'hB2B2_0002;
        ctrl_pat[2] = 32'hC3C3_0003;
        ctrl_pat[3] = 32'hD4D4_0004;
        bus.fsm_ctrl = {ctrl_pat[3], ctrl_pat[2], ctrl_pat[1], ctrl_pat[0]};

        //            code          lat done stray    run   g   cause
        vecs[0]  = '{32'h0100_0000, 2,  4,   4'b0000, 1'b1, 2,  2'b00};
        vecs[1]  = '{32'h0000_0008, 1,  1,   4'b0000, 1'b0, 0,  2'b00};
        vecs[2]  = '{32'h0010_0000, 3,  2,   4'b0000, 1'b1, 1,  2'b00};
        vecs[3]  = '{32'h0800_0000, 1,  5,   4'b0011, 1'b1, 3,  2'b00};
        vecs[4]  = '{32'h0200_0000, 2,  3,   4'b0010, 1'b0, 2,  2'b00};
        vecs[5]  = '{32'h0000_0000, 1,  0,   4'b0000, 1'b1, -1, 2'b01};
        vecs[6]  = '{32'h8000_0000, 1,  0,   4'b0000, 1'b1, -1, 2'b01};
        vecs[7]  = '{32'h0100_0001, 1,  0,   4'b0000, 1'b1, -1, 2'b11};
        vecs[8]  = '{32'h0003_0000, 1,  1,   4'b0000, 1'b1, 1,  2'b00};
        vecs[9]  = '{32'h0000_0100, 1,  0,   4'b0000, 1'b1, 0,  2'b10};
        vecs[10] = '{32'h0400_0000, 1,  64,  4'b0001, 1'b1, 3,  2'b00};
        vecs[11] = '{32'h0000_8000, 1,  63,  4'b0000, 1'b1, 0,  2'b00};

        for (int i = 0; i < 12; i++) begin
            cur = i;
            do_reset();
            run_instr(vecs[i]);
            if (vecs[i].exp_g >= 0 && vecs[i].done_cyc != 0 && !vecs[i].run_keep) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stopped_fetch", bus.fetch_start, 0);
                    chk("stopped_busy", bus.busy, 0);
                end
                bus.run = 1'b1;
                @(negedge clk);
                chk("resume_fetch", bus.fetch_start, 1);
            end
        end

        // retire counter wrap from a preloaded all-ones count
        cur = 12;
        do_reset();
        force dut.retired_q = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        release dut.retired_q;
        exp_ret = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("preload", bus.retired, exp_ret);
        hv = '{32'h0100_0000, 1, 1, 4'b0000, 1'b0, 2, 2'b00};
        run_instr(hv);

        // asynchronous reset while waiting for instruction memory
        cur = 13;
        run_instr(hv);
        bus.run = 1'b1;
        @(negedge clk);
        chk("ar_fetch", bus.fetch_start, 1);
        @(negedge clk);
        chk("ar_wait_busy", bus.busy, 1);
        bus.fetch_done = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", bus.busy, 0);
        chk("ar_load_ir", bus.load_ir, 0);
        chk("ar_retired", bus.retired, 0);
        chk("ar_fetch_start", bus.fetch_start, 0);
        chk("ar_fsm_start", bus.fsm_start, 0);
        chk("ar_ctrl", bus.ctrl_out, 0);
        chk("ar_trap", bus.trap, 0);
        bus.fetch_done = 1'b0;
        bus.run        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/control_dispatcher.md
Name: control_dispatcher

Overview:
- Top-level sequencer of the Control Unit.
- Runs instruction fetch, then starts exactly one specialised FSM (ALU, load/store, branch/jump, float) per instruction, chosen from the opdecoder one-hot code.
- Routes the granted FSM's packed control bundle to the DataFlow and waits for its done.
- Adds a hung-FSM watchdog, illegal-opcode trap, graceful stop and a retired-instruction counter.

Parameters:
- N_FSM, 4, number of sub-FSMs served.
- CTRL_W, 32, width of one packed control bundle (same bit order for every FSM).
- TIMEOUT, 64, maximum cycles a granted FSM may stay busy before trapping.
- CLASS_MASK, {4 x 32-bit constants from package}, code bits belonging to each FSM. Index 0 is the LSB slice.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop after the current instruction.
- code  in  32  one-hot class from opdecoder, valid from DECODE onward.
- fetch_done  in  1  instruction memory read complete (1-cycle pulse).
- fsm_done  in  N_FSM  done flags from the sub-FSMs.
- fsm_ctrl  in  N_FSM*CTRL_W  packed control bundles; slice i = FSM i.
- fetch_start  out  1  1-cycle request to memory for the instruction at pc.
- load_ir  out  1  latch the instruction register.
- fsm_start  out  N_FSM  one-hot start pulse.
- ctrl_out  out  CTRL_W  muxed bundle to the DataFlow.
- busy  out  1  high in every state except IDLE and TRAP.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 = illegal code, 10 = timeout, 11 = multiple class match.
- retired  out  32  count of completed instructions.

Behaviour:
- Reset (async on rst_n low):
  - state = IDLE, grant = 0, watchdog = 0, retired = 0.
  - trap = 0, trap_cause = 00.
  - All pulse outputs 0; ctrl_out = 0.
- States:
  - IDLE: run = 1 -> FETCH.
  - FETCH: fetch_start = 1 for one cycle -> FETCH_WAIT.
  - FETCH_WAIT: wait for fetch_done; that cycle load_ir = 1 -> DECODE.
  - DECODE: settle cycle for code. Compute match[i] = |(code & CLASS_MASK[i]).
    - match == 0 -> TRAP, cause 01.
    - popcount(match) > 1 -> TRAP, cause 11.
    - otherwise grant <= index of the match -> DISPATCH.
  - DISPATCH: fsm_start[grant] = 1 for exactly one cycle -> BUSY. Watchdog cleared.
  - BUSY: ctrl_out = fsm_ctrl slice[grant]. Watchdog increments each cycle.
    - fsm_done[grant] = 1 -> retired += 1 (wraps modulo 2^32); next = FETCH if run = 1, else IDLE.
    - Watchdog reaches TIMEOUT-1 with no done -> TRAP, cause 10.
  - TRAP: trap = 1, ctrl_out = 0. Held until rst_n is asserted (no software exit).
- ctrl_out is 0 in all states except DISPATCH and BUSY. In DISPATCH it equals the granted slice.
- ctrl_out is combinational from state, grant and fsm_ctrl. The sub-FSM drives its done and writeback controls in the same cycle, so no added latency.
- fsm_done bits of non-granted FSMs are ignored.
- If done and the watchdog limit occur in the same cycle, done wins (retire, no trap).
- run dropping mid-instruction never aborts: the current instruction completes and retires, then the block goes to IDLE.
- fetch_done outside FETCH_WAIT is ignored.
- Minimum per-instruction overhead: FETCH, FETCH_WAIT (≥1 cycle), DECODE, DISPATCH = 4 cycles before the FSM's own latency.
- A branch/jump FSM with 5 internal cycles therefore retires in 4 + its BUSY cycles.
- Reset asserted mid-instruction: immediate return to IDLE with every output at its reset value. The sub-FSMs are reset by the same rst_n.

Decomposition:
- Package cu_pkg:
  - state encoding localparams (IDLE..TRAP, 3 bits).
  - CLASS_MASK constants per FSM, consistent with the opdecoder code bit assignments (e.g. bits 24/25 = branch/jump class).
  - trap cause codes.
  - CTRL_W bundle bit-field offsets (sel_rd, load_pc, load_regfile, …).
- Sub-module: dispatch_match. Combinational code -> {grant index, none, multi} encoder, reused by the verification scoreboard.

Test Plan:
- Reset, run=1, fetch_done 2 cycles after fetch_start, code=1<<24 (branch class, FSM 2), fsm_done[2] on 4th BUSY cycle -> fsm_start=0100 for one cycle; ctrl_out tracks slice 2; retired=1; fetch_start re-asserts the next cycle.
- code=0 in DECODE -> trap=1, trap_cause=01, fsm_start never pulses, retired unchanged, state holds until rst_n low.
- Granted FSM never signals done, TIMEOUT=64 -> trap at the 64th BUSY cycle with cause 10. Repeat with done exactly on cycle 64 -> retires, no trap.
- run dropped during BUSY -> instruction retires, busy=0 the next cycle, no fetch_start. Re-raising run -> fetch resumes.
- fsm_done[1] pulses while grant=2 -> ignored, no retire; code with bits in two masks -> trap_cause=11.
- Counter wrap: preload retired to 0xFFFFFFFF via forced state, retire one instruction -> retired=0. Async rst_n pulse mid-FETCH_WAIT -> all outputs 0 immediately.
